tiny_dnn_prm_loader: RTL and testbench
======================================

Name: tiny_dnn_prm_loader

Overview:
- Parametrised parameter-load engine for the tiny_dnn core array; next generation of the array-level weight/bias write path.
- Takes the LANES-wide source stream, walks group and address counters, and issues registered per-core write strobes, address and data to F_NUM cores.
- Handles any F_NUM/LANES ratio, depth ADDR_W, weight and bias modes, consumer backpressure and stream framing checks.
- Sits between the source stream handshake and the core array, replacing ad-hoc prm_v/prm_a decode.

Parameters:
- F_NUM, 16, number of cores; must be an integer multiple of LANES.
- LANES, 4, data words per source beat.
- DATA_W, 16, bits per data word (fixed point).
- ADDR_W, 10, core parameter RAM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe; begins a load when IDLE.
- bias_mode  in  1  sampled at start: 1 = bias load (single address), 0 = weight load.
- ks  in  ADDR_W  last weight address (load covers ks+1 addresses); sampled at start.
- abort  in  1  synchronous return to IDLE, no done pulse.
- src_valid  in  1  source beat valid.
- src_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- src_last  in  1  source marks final beat.
- src_ready  out  1  loader accepts beat.
- prm_stall  in  1  core array cannot take a write this cycle.
- wr_en  out  F_NUM  per-core write strobe.
- wr_addr  out  ADDR_W  parameter RAM address.
- wr_data  out  F_NUM*DATA_W  core i gets lane i%LANES.
- wr_bias  out  1  write targets bias register.
- busy  out  1  state is LOAD.
- done  out  1  one-cycle pulse after final write.
- frame_err  out  1  sticky framing error, cleared by start.

Behaviour:
- Reset: state IDLE; all outputs 0; counters g=0, a=0.
- G = F_NUM/LANES beats per address.
- States: IDLE -> LOAD on start; LOAD -> FIN on accept of final beat (g=G-1 and a=a_end, where a_end = 0 if bias_mode else ks); FIN -> IDLE unconditionally after one cycle, with done=1 in FIN.
- start while LOAD or FIN: ignored.
- src_ready = (state==LOAD) & ~prm_stall. Accept = src_valid & src_ready.
- Count order: g increments per accept; on g=G-1 wrap g to 0 and increment a. Address never exceeds a_end.
- Write timing: outputs registered, one cycle after accept. wr_en bits [g*LANES +: LANES] = 1, others 0; wr_addr = a; wr_data = lanes replicated G times; wr_bias = latched bias_mode. With no accept, wr_en = 0 next cycle; wr_addr, wr_data and wr_bias hold.
- prm_stall deasserts src_ready the same cycle. Any write already registered still completes, so the consumer must tolerate one write during the first stall cycle.
- done asserts in the same cycle as the final wr_en.
- frame_err is set on an accepted beat when src_last=1 but the beat is not final, or the final beat has src_last=0. The load still completes by count.
- abort takes priority over all transitions: state IDLE, counters 0, wr_en 0 next cycle, done not pulsed, frame_err held.
- ks=0 or bias_mode: exactly G beats.
- Async reset mid-LOAD: immediate clear; a subsequent start begins from g=0, a=0.

Optional Feature:
- Macro TINY_DNN_PRM_ZERO_SKIP_EN.
- When defined: a beat whose LANES words are all zero is accepted and counted, but its wr_en is suppressed (all 0), saving RAM writes on zero-initialised arrays.
- When undefined: every accepted beat produces a strobe, as specified above.

Test Plan:
- F_NUM=16, LANES=4, ks=2, weight mode, src_valid held, src_last on beat 12 -> 12 writes. Addresses 0,0,0,0,1,...,2; wr_en 0x000F,0x00F0,0x0F00,0xF000 repeating; done coincides with the 12th write; frame_err=0.
- bias_mode=1, ks=5 -> 4 beats, wr_addr=0, wr_bias=1, done after 4th write.
- prm_stall high for 3 cycles after beat 2 -> src_ready low for those 3 cycles; no beat lost or duplicated; write sequence identical to test 1.
- src_last on beat 5 of 12 -> frame_err=1 after beat 5. Load completes with 12 writes; next start clears frame_err.
- abort after beat 6 -> busy=0 next cycle, no done pulse. New start with ks=0 yields 4 writes at address 0.
- TINY_DNN_PRM_ZERO_SKIP_EN defined, beat 3 all zeros -> no wr_en for that beat; counters advance; done still pulses after beat 12.

Source files
------------

// File: rtl/tiny_dnn_prm_loader.sv
// tiny_dnn_prm_loader: parameter-load engine for the tiny_dnn core array.
// Consumes a LANES-wide source stream. Group (g) and address (a) counters
// turn it into registered per-core write strobes, an address and data for
// F_NUM cores.
// Optional feature: define TINY_DNN_PRM_ZERO_SKIP_EN to suppress the write
// strobes of beats whose lanes are all zero (the beat is still counted).
module tiny_dnn_prm_loader #(
    parameter int F_NUM  = 16,
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      bias_mode,
    input  logic [ADDR_W-1:0]         ks,
    input  logic                      abort,
    input  logic                      src_valid,
    input  logic [LANES*DATA_W-1:0]   src_data,
    input  logic                      src_last,
    output logic                      src_ready,
    input  logic                      prm_stall,
    output logic [F_NUM-1:0]          wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [F_NUM*DATA_W-1:0]   wr_data,
    output logic                      wr_bias,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_err
);

    localparam int G   = F_NUM / LANES;
    localparam int G_W = (G > 1) ? $clog2(G) : 1;
    localparam logic [G_W-1:0] G_LAST = G_W'(G - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    logic [G_W-1:0]    g;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] a_end;
    logic              bias_lat;
    logic              accept;
    logic              last_beat;
    logic [F_NUM-1:0]  en_next;

    assign src_ready = (state == LOAD) & ~prm_stall;
    assign busy      = (state == LOAD);
    assign accept    = src_valid & src_ready;
    assign last_beat = (g == G_LAST) && (a == a_end);

    // Strobe the LANES cores belonging to the current group
    always_comb begin
        en_next = '0;
        for (int unsigned i = 0; i < G; i++) begin
            if (g == G_W'(i)) begin
                en_next[i*LANES +: LANES] = '1;
            end
        end
`ifdef TINY_DNN_PRM_ZERO_SKIP_EN
        if (src_data == '0) begin
            en_next = '0;
        end
`else
`endif
    end

    // Load FSM, counters and registered write outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            a         <= '0;
            a_end     <= '0;
            bias_lat  <= 1'b0;
            wr_en     <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_bias   <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_en <= '0;
            done  <= 1'b0;
            if (abort) begin
                state <= IDLE;
                g     <= '0;
                a     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= LOAD;
                            g         <= '0;
                            a         <= '0;
                            a_end     <= bias_mode ? '0 : ks;
                            bias_lat  <= bias_mode;
                            frame_err <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            wr_en   <= en_next;
                            wr_addr <= a;
                            wr_data <= {G{src_data}};
                            wr_bias <= bias_lat;
                            if (src_last != last_beat) begin
                                frame_err <= 1'b1;
                            end
                            if (last_beat) begin
                                state <= FIN;
                                done  <= 1'b1;
                                g     <= '0;
                                a     <= '0;
                            end else if (g == G_LAST) begin
                                g <= '0;
                                a <= a + 1'b1;
                            end else begin
                                g <= g + 1'b1;
                            end
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tiny_dnn_prm_loader.sv
// Self-checking bench for tiny_dnn_prm_loader.
// A bench-side model predicts each write when a beat is driven. The write is
// pushed to a scoreboard queue tagged with its expected cycle. A negedge
// monitor pops the entry and compares it when the DUT output appears.
module tb_tiny_dnn_prm_loader;

    localparam int F_NUM  = 16;
    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int G      = F_NUM / LANES;
    localparam int SW     = LANES * DATA_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    bias_mode;
    logic [ADDR_W-1:0]       ks;
    logic                    abort;
    logic                    src_valid;
    logic [SW-1:0]           src_data;
    logic                    src_last;
    logic                    src_ready;
    logic                    prm_stall;
    logic [F_NUM-1:0]        wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [F_NUM*DATA_W-1:0] wr_data;
    logic                    wr_bias;
    logic                    busy;
    logic                    done;
    logic                    frame_err;

    tiny_dnn_prm_loader #(
        .F_NUM (F_NUM),
        .LANES (LANES),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bias_mode(bias_mode),
        .ks       (ks),
        .abort    (abort),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_last (src_last),
        .src_ready(src_ready),
        .prm_stall(prm_stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_bias  (wr_bias),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err    = 0;
    int n_checks = 0;

    typedef struct {
        int                      cyc;
        logic [F_NUM-1:0]        en;
        logic [ADDR_W-1:0]       addr;
        logic [F_NUM*DATA_W-1:0] data;
        logic                    bias;
        logic                    fin;
    } exp_t;

    exp_t q[$];

    // model state: 0 idle, 1 load, 2 fin (state after the coming edge)
    int                m_state = 0;
    int                m_g     = 0;
    int                m_a     = 0;
    int                m_aend  = 0;
    logic              m_bias  = 1'b0;
    logic              m_ferr  = 1'b0;

    // Scoreboard monitor: compare a due write, otherwise require a quiet bus
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if (wr_en !== e.en || wr_addr !== e.addr || wr_data !== e.data ||
                    wr_bias !== e.bias || done !== e.fin) begin
                    n_err++;
                    $display("FAIL write cyc=%0d: got en=%h addr=%0d bias=%b done=%b data=%h, want en=%h addr=%0d bias=%b done=%b data=%h",
                             cyc, wr_en, wr_addr, wr_bias, done, wr_data,
                             e.en, e.addr, e.bias, e.fin, e.data);
                end
            end else begin
                n_checks++;
                if (wr_en !== '0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL quiet cyc=%0d: got en=%h done=%b, want en=0 done=0",
                             cyc, wr_en, done);
                end
            end
        end
    end

    // Drive one cycle of inputs, check ready/busy/frame_err and advance the model
    task automatic drive(input logic st, input logic bm, input logic [ADDR_W-1:0] k,
                         input logic ab, input logic v, input logic [SW-1:0] d,
                         input logic lst, input logic stl, output logic acc);
        logic             exp_ready;
        logic             fin;
        logic [F_NUM-1:0] en;
        exp_t             e;
        @(negedge clk);
        start = st; bias_mode = bm; ks = k; abort = ab;
        src_valid = v; src_data = d; src_last = lst; prm_stall = stl;
        #1;
        exp_ready = (m_state == 1) && !stl;
        n_checks += 3;
        if (src_ready !== exp_ready) begin
            n_err++;
            $display("FAIL src_ready cyc=%0d: got %b want %b", cyc, src_ready, exp_ready);
        end
        if (busy !== (m_state == 1)) begin
            n_err++;
            $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, (m_state == 1));
        end
        if (frame_err !== m_ferr) begin
            n_err++;
            $display("FAIL frame_err cyc=%0d: got %b want %b", cyc, frame_err, m_ferr);
        end
        acc = 1'b0;
        if (ab) begin
            m_state = 0; m_g = 0; m_a = 0;
        end else if (m_state == 0) begin
            if (st) begin
                m_state = 1; m_g = 0; m_a = 0;
                m_bias = bm; m_aend = bm ? 0 : int'(k); m_ferr = 1'b0;
            end
        end else if (m_state == 1) begin
            if (v && !stl) begin
                acc = 1'b1;
                fin = (m_g == G - 1) && (m_a == m_aend);
                en  = {{(F_NUM-LANES){1'b0}}, {LANES{1'b1}}} << (m_g * LANES);
`ifdef TINY_DNN_PRM_ZERO_SKIP_EN
                if (d == '0) en = '0;
`else
`endif
                e.cyc = cyc + 1; e.en = en; e.addr = ADDR_W'(m_a);
                e.data = {G{d}}; e.bias = m_bias; e.fin = fin;
                q.push_back(e);
                if (lst != fin) m_ferr = 1'b1;
                if (fin) begin
                    m_state = 2; m_g = 0; m_a = 0;
                end else if (m_g == G - 1) begin
                    m_g = 0; m_a++;
                end else begin
                    m_g++;
                end
            end
        end else begin
            m_state = 0;
        end
    endtask

    // Generic load: start, stream beats with optional last/stall/zero/abort/start events
    task automatic run_load(input logic bm, input int k, input int nbeats, input int last_at,
                            input int stall_after, input int stall_len, input int zero_at,
                            input int abort_after, input int start_at);
        logic          acc;
        logic          stl;
        logic [SW-1:0] d;
        int            beats = 0;
        int            stall_left = 0;
        int            iter = 0;
        drive(1'b1, bm, ADDR_W'(k), 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        while (beats < nbeats && iter < 200) begin
            iter++;
            d = SW'({$urandom(), $urandom()});
            d[0] = 1'b1;
            if (beats + 1 == zero_at) d = '0;
            if (abort_after > 0 && beats == abort_after) begin
                drive(1'b0, 1'b0, '0, 1'b1, 1'b1, d, 1'b0, 1'b0, acc);
                break;
            end
            stl = (stall_left > 0);
            if (beats + 1 == start_at)
                drive(1'b1, 1'b1, ADDR_W'(7), 1'b0, 1'b1, d, (beats + 1 == last_at), stl, acc);
            else
                drive(1'b0, 1'b0, '0, 1'b0, 1'b1, d, (beats + 1 == last_at), stl, acc);
            if (stl) stall_left--;
            if (acc) begin
                beats++;
                if (stall_after > 0 && beats == stall_after) stall_left = stall_len;
            end
        end
        n_checks++;
        if (iter >= 200) begin
            n_err++;
            $display("FAIL load_timeout: got %0d beats, want %0d", beats, nbeats);
        end
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; bias_mode = 0; ks = '0; abort = 0;
        src_valid = 0; src_data = '0; src_last = 0; prm_stall = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_en !== '0 || wr_addr !== '0 || wr_data !== '0 || wr_bias !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0 || src_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got en=%h addr=%0d bias=%b busy=%b done=%b ferr=%b rdy=%b, want all 0",
                     wr_en, wr_addr, wr_bias, busy, done, frame_err, src_ready);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_weight();      run_load(1'b0, 2, 12, 12, 0, 0, 0, 0, 0); endtask
    task automatic test_bias();        run_load(1'b1, 5, 4, 4, 0, 0, 0, 0, 0);   endtask
    task automatic test_stall();       run_load(1'b0, 2, 12, 12, 2, 3, 0, 0, 0); endtask
    task automatic test_start_ignored(); run_load(1'b0, 1, 8, 8, 0, 0, 0, 0, 3); endtask
    task automatic test_zero_skip();   run_load(1'b0, 2, 12, 12, 0, 0, 3, 0, 0); endtask

    task automatic test_frame_err();
        run_load(1'b0, 2, 12, 5, 0, 0, 0, 0, 0);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL frame_err_sticky: got %b want 1", frame_err);
        end
        // next start clears it (checked per cycle against the model)
        run_load(1'b0, 0, 4, 4, 0, 0, 0, 0, 0);
    endtask

    task automatic test_abort();
        run_load(1'b0, 2, 12, 12, 0, 0, 0, 6, 0);
        run_load(1'b0, 0, 4, 4, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        logic acc;
        drive(1'b1, 1'b0, ADDR_W'(2), 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, '0, 1'b0, 1'b1, SW'(i + 1), 1'b0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || wr_en !== '0 || src_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b en=%h rdy=%b, want 0", busy, wr_en, src_ready);
        end
        q.delete();
        m_state = 0; m_g = 0; m_a = 0; m_ferr = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_load(1'b0, 0, 4, 4, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_weight();
        test_bias();
        test_stall();
        test_frame_err();
        test_abort();
        test_start_ignored();
        test_zero_skip();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
